// File: rtl/game_flow_if.sv
// game_flow_if: bundles the game controller's key/event inputs and status outputs
interface game_flow_if #(
    parameter int NUM_STARS = 3
);
    logic                 tick_hsec;
    logic                 enter;
    logic                 pause_key;
    logic                 hit;
    logic [NUM_STARS-1:0] star_pulse;
    logic                 at_goal;
    logic [2:0]           state;
    logic [11:0]          time_bcd;
    logic [2:0]           hp;
    logic [NUM_STARS-1:0] stars_got;
    logic                 all_stars;
    logic [2:0]           level;
    logic [3:0]           wait_digit;
    logic                 sfx;

    modport master (
        output tick_hsec, enter, pause_key, hit, star_pulse, at_goal,
        input  state, time_bcd, hp, stars_got, all_stars, level, wait_digit, sfx
    );

    modport slave (
        input  tick_hsec, enter, pause_key, hit, star_pulse, at_goal,
        output state, time_bcd, hp, stars_got, all_stars, level, wait_digit, sfx
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round FSM with BCD timer, HP/invulnerability, stars and levels; PAUSE enabled by GAME_FLOW_PAUSE_EN
module game_flow_ctrl #(
    parameter int START_MIN  = 1,
    parameter int START_SEC  = 47,
    parameter int WAIT_TICKS = 6,
    parameter int MAX_HP     = 3,
    parameter int NUM_STARS  = 3,
    parameter int NUM_LEVELS = 4,
    parameter int INV_TICKS  = 2
) (
    input logic        clk,
    input logic        rst_n,
    game_flow_if.slave bus
);
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_WAIT  = 3'd1,
        S_GAME  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4,
        S_PAUSE = 3'd5
    } state_t;

`ifdef GAME_FLOW_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam logic [11:0] TIME_START = {4'(START_MIN), 4'(START_SEC / 10), 4'(START_SEC % 10)};

    // One-second BCD decrement that sticks at 0:00
    function automatic logic [11:0] bcd_dec(input logic [11:0] t);
        logic [3:0] m, tn, on;
        {m, tn, on} = t;
        if (t == 12'h000) return t;
        if (on != 4'd0) return {m, tn, on - 4'd1};
        if (tn != 4'd0) return {m, tn - 4'd1, 4'd9};
        return {m - 4'd1, 4'd5, 4'd9};
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d, inv_q, inv_d, wait_digit_q, wait_digit_d;
    logic [11:0]          time_q, time_d;
    logic [2:0]           hp_q, hp_d, level_q, level_d;
    logic [NUM_STARS-1:0] stars_q, stars_d;
    logic                 all_q, all_d, phase_q, phase_d, sfx_q, sfx_d;
    logic                 in_game, hit_ok, win, lose, pause_go;
    logic [4:0]           wd_raw;

    assign in_game  = state_q == S_GAME;
    assign hit_ok   = in_game && bus.hit && inv_q == 4'd0;
    assign win      = in_game && bus.at_goal && all_q;
    assign lose     = in_game && (time_q == 12'h000 || hp_q == 3'd0);
    assign pause_go = PAUSE_EN && in_game && bus.pause_key;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // Next-state logic; win is tested before lose so it takes priority
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:        if (bus.enter) state_d = S_WAIT;
            S_WAIT:        if (bus.tick_hsec && cnt_q + 4'd1 == 4'(WAIT_TICKS)) state_d = S_GAME;
            S_GAME:        state_d = win ? S_WIN : lose ? S_LOSE : pause_go ? S_PAUSE : S_GAME;
            S_WIN, S_LOSE: if (bus.enter) state_d = S_WAIT;
            S_PAUSE:       state_d = !PAUSE_EN ? S_INIT : bus.pause_key ? S_GAME : S_PAUSE;
            default:       state_d = S_INIT;
        endcase
    end

    // Datapath and registered-output next values; round setup on WAIT entry overrides everything
    always_comb begin
        cnt_d   = cnt_q;
        time_d  = time_q;
        hp_d    = hp_q;
        stars_d = stars_q;
        inv_d   = inv_q;
        phase_d = phase_q;
        level_d = level_q;
        if (in_game) begin
            if (bus.tick_hsec) begin
                phase_d = ~phase_q;
                if (phase_q) time_d = bcd_dec(time_q);
            end
            if (hit_ok) begin
                hp_d  = hp_q - {2'b00, hp_q != 3'd0};
                inv_d = 4'(INV_TICKS);
            end else if (bus.tick_hsec && inv_q != 4'd0) begin
                inv_d = inv_q - 4'd1;
            end
            stars_d = stars_q | bus.star_pulse;
        end
        if (state_q == S_WAIT && bus.tick_hsec) cnt_d = cnt_q + 4'd1;
        if (state_q == S_WAIT && state_d == S_GAME) phase_d = 1'b0;
        if (state_q == S_WIN && state_d == S_WAIT) level_d = level_q == 3'(NUM_LEVELS - 1) ? 3'd0 : level_q + 3'd1;
        if (state_q == S_LOSE && state_d == S_WAIT) level_d = 3'd0;
        if (state_q != S_WAIT && state_d == S_WAIT) begin
            cnt_d   = 4'd0;
            time_d  = TIME_START;
            hp_d    = 3'(MAX_HP);
            stars_d = '0;
            inv_d   = 4'd0;
        end
        all_d        = &stars_d;
        wd_raw       = 5'(WAIT_TICKS + 1) - {1'b0, cnt_d};
        wait_digit_d = state_d == S_WAIT ? 4'(wd_raw >> 1) : 4'd0;
        sfx_d        = in_game && (hit_ok || |(bus.star_pulse & ~stars_q));
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 4'd0;
            time_q       <= TIME_START;
            hp_q         <= 3'(MAX_HP);
            stars_q      <= '0;
            all_q        <= 1'b0;
            inv_q        <= 4'd0;
            phase_q      <= 1'b0;
            level_q      <= 3'd0;
            wait_digit_q <= 4'd0;
            sfx_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            time_q       <= time_d;
            hp_q         <= hp_d;
            stars_q      <= stars_d;
            all_q        <= all_d;
            inv_q        <= inv_d;
            phase_q      <= phase_d;
            level_q      <= level_d;
            wait_digit_q <= wait_digit_d;
            sfx_q        <= sfx_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.time_bcd   = time_q;
    assign bus.hp         = hp_q;
    assign bus.stars_got  = stars_q;
    assign bus.all_stars  = all_q;
    assign bus.level      = level_q;
    assign bus.wait_digit = wait_digit_q;
    assign bus.sfx        = sfx_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed vector table plus hand sequences for game_flow_ctrl
module tb_game_flow_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    game_flow_if #(.NUM_STARS(3)) bus ();

    game_flow_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        en, tk, pk, ht;
        logic [2:0]  st;
        logic        gl;
        logic [2:0]  e_state;
        logic [11:0] e_time;
        logic [2:0]  e_hp;
        logic [2:0]  e_stars;
        logic [2:0]  e_level;
        logic [3:0]  e_wd;
        logic        e_sfx;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic en, tk, pk, ht, input logic [2:0] st, input logic gl,
                                input logic [2:0] es, input logic [11:0] et, input logic [2:0] eh,
                                input logic [2:0] estar, input logic [2:0] el, input logic [3:0] ewd,
                                input logic esfx);
        vec_t r;
        r.en = en; r.tk = tk; r.pk = pk; r.ht = ht; r.st = st; r.gl = gl;
        r.e_state = es; r.e_time = et; r.e_hp = eh; r.e_stars = estar;
        r.e_level = el; r.e_wd = ewd; r.e_sfx = esfx;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        bus.enter = 0; bus.tick_hsec = 0; bus.pause_key = 0; bus.hit = 0;
        bus.star_pulse = 3'b000; bus.at_goal = 0;
    endtask

    task automatic cyc(input logic en, tk, pk, ht, input logic [2:0] st, input logic gl);
        @(negedge clk);
        bus.enter = en; bus.tick_hsec = tk; bus.pause_key = pk; bus.hit = ht;
        bus.star_pulse = st; bus.at_goal = gl;
        @(posedge clk);
        #1 clr();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 3'b000, 0);
    endtask

    initial begin
        clr();
        // en tk pk ht star goal | state time hp stars level wd sfx
        vt.push_back(mk(0,1,1,1,3'b111,1, 3'd0,12'h147,3'd3,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(1,0,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd3,0));
        vt.push_back(mk(0,0,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd3,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd3,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd2,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd2,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd1,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd0,4'd1,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h147,3'd3,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h147,3'd3,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h146,3'd3,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(1,0,0,0,3'b000,0, 3'd2,12'h146,3'd3,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,0,0,1,3'b000,0, 3'd2,12'h146,3'd2,3'b000,3'd0,4'd0,1));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h146,3'd2,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,0,0,1,3'b000,0, 3'd2,12'h146,3'd2,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h145,3'd2,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h145,3'd2,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,0,0,1,3'b000,0, 3'd2,12'h145,3'd1,3'b000,3'd0,4'd0,1));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h144,3'd1,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,1,0,0,3'b000,0, 3'd2,12'h144,3'd1,3'b000,3'd0,4'd0,0));
        vt.push_back(mk(0,0,0,0,3'b011,0, 3'd2,12'h144,3'd1,3'b011,3'd0,4'd0,1));
        vt.push_back(mk(0,0,0,0,3'b011,0, 3'd2,12'h144,3'd1,3'b011,3'd0,4'd0,0));
        vt.push_back(mk(0,0,0,1,3'b100,1, 3'd2,12'h144,3'd0,3'b111,3'd0,4'd0,1));
        vt.push_back(mk(0,0,0,0,3'b000,1, 3'd3,12'h144,3'd0,3'b111,3'd0,4'd0,0));
        vt.push_back(mk(0,1,0,1,3'b111,1, 3'd3,12'h144,3'd0,3'b111,3'd0,4'd0,0));
        vt.push_back(mk(1,0,0,0,3'b000,0, 3'd1,12'h147,3'd3,3'b000,3'd1,4'd3,0));

        #12;
        chk("rst_state", bus.state, 3'd0);
        chk("rst_time", bus.time_bcd, 12'h147);
        chk("rst_hp", bus.hp, 3'd3);
        chk("rst_stars", bus.stars_got, 3'b000);
        chk("rst_all", bus.all_stars, 1'b0);
        chk("rst_level", bus.level, 3'd0);
        chk("rst_wd", bus.wait_digit, 4'd0);
        chk("rst_sfx", bus.sfx, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            cyc(vt[i].en, vt[i].tk, vt[i].pk, vt[i].ht, vt[i].st, vt[i].gl);
            chk($sformatf("v%0d_state", i), bus.state, vt[i].e_state);
            chk($sformatf("v%0d_time", i), bus.time_bcd, vt[i].e_time);
            chk($sformatf("v%0d_hp", i), bus.hp, vt[i].e_hp);
            chk($sformatf("v%0d_stars", i), bus.stars_got, vt[i].e_stars);
            chk($sformatf("v%0d_all", i), bus.all_stars, &vt[i].e_stars);
            chk($sformatf("v%0d_level", i), bus.level, vt[i].e_level);
            chk($sformatf("v%0d_wd", i), bus.wait_digit, vt[i].e_wd);
            chk($sformatf("v%0d_sfx", i), bus.sfx, vt[i].e_sfx);
        end

        // Timer BCD borrow chain down to 0:00, then LOSE with timer held
        ticks(6);
        chk("t_game", bus.state, 3'd2);
        ticks(94);
        chk("t_100", bus.time_bcd, 12'h100);
        ticks(2);
        chk("t_059", bus.time_bcd, 12'h059);
        ticks(118);
        chk("t_000", bus.time_bcd, 12'h000);
        chk("t_still_game", bus.state, 3'd2);
        cyc(0, 0, 0, 0, 3'b000, 0);
        chk("t_lose", bus.state, 3'd4);
        ticks(2);
        chk("t_held", bus.time_bcd, 12'h000);
        chk("t_lose_stay", bus.state, 3'd4);
        cyc(1, 0, 0, 0, 3'b000, 0);
        chk("t_wait", bus.state, 3'd1);
        chk("t_level0", bus.level, 3'd0);
        chk("t_reload", bus.time_bcd, 12'h147);
        ticks(6);
        chk("p_game", bus.state, 3'd2);

        // Pause toggling
        cyc(0, 0, 1, 0, 3'b000, 0);
`ifdef GAME_FLOW_PAUSE_EN
        chk("p_enter", bus.state, 3'd5);
        ticks(10);
        chk("p_time_frozen", bus.time_bcd, 12'h147);
        cyc(0, 0, 0, 1, 3'b000, 0);
        chk("p_hit_ignored", bus.hp, 3'd3);
        cyc(0, 0, 1, 0, 3'b000, 0);
        chk("p_resume", bus.state, 3'd2);
        ticks(2);
        chk("p_phase_kept", bus.time_bcd, 12'h146);
`else
        chk("p_ignored", bus.state, 3'd2);
        ticks(10);
        chk("p_time_runs", bus.time_bcd, 12'h142);
        cyc(0, 0, 0, 1, 3'b000, 0);
        chk("p_hit_taken", bus.hp, 3'd2);
        cyc(0, 0, 1, 0, 3'b000, 0);
        chk("p_still_game", bus.state, 3'd2);
        ticks(2);
        chk("p_time_more", bus.time_bcd, 12'h141);
`endif

        // Win again to get a nonzero level, then reset mid-round
        cyc(0, 0, 0, 0, 3'b111, 0);
        chk("r_star_sfx", bus.sfx, 1'b1);
        cyc(0, 0, 0, 0, 3'b000, 1);
        chk("r_win", bus.state, 3'd3);
        cyc(1, 0, 0, 0, 3'b000, 0);
        chk("r_level1", bus.level, 3'd1);
        ticks(6);
        chk("r_game", bus.state, 3'd2);
        cyc(0, 0, 0, 1, 3'b000, 0);
        chk("r_hit_sfx", bus.sfx, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_state", bus.state, 3'd0);
        chk("r_level", bus.level, 3'd0);
        chk("r_sfx", bus.sfx, 1'b0);
        chk("r_time", bus.time_bcd, 12'h147);
        chk("r_hp", bus.hp, 3'd3);
        cyc(0, 0, 0, 1, 3'b111, 0);
        chk("r_hold_sfx", bus.sfx, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 1, 0, 0, 3'b000, 0);
        chk("r_init", bus.state, 3'd0);
        cyc(1, 0, 0, 0, 3'b000, 0);
        chk("r_wait", bus.state, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
